// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state types and round helper functions
package sha256_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  // Working state a..h packed so that index 7 is a and index 0 is h.
  typedef logic [7:0][31:0]  sha_state_t;
  typedef logic [15:0][31:0] w_window_t;

  localparam sha_state_t H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Next schedule word from W[t-2], W[t-7], W[t-15], W[t-16].
  function automatic logic [31:0] sched_word(input logic [31:0] w2, w7, w15, w16);
    return small_sigma1(w2) + w7 + small_sigma0(w15) + w16;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
  import sha256_pkg::*;
(
  input  sha_state_t  st_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output sha_state_t  st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1   = st_i[0] + big_sigma1(st_i[3]) + ch(st_i[3], st_i[2], st_i[1]) + k_i + w_i;
    t2   = big_sigma0(st_i[7]) + maj(st_i[7], st_i[6], st_i[5]);
    st_o = {t1 + t2, st_i[7], st_i[6], st_i[5], st_i[4] + t1, st_i[3], st_i[2], st_i[1]};
  end

endmodule

// File: rtl/sha256_top.sv
// rtl/sha256_top.sv - single-block SHA-256 engine: padding, W window, FSM, digest register
// SHA256_UNROLL2_EN selects two chained rounds per clock.
module sha256_top
  import sha256_pkg::*;
#(
  parameter int MSG_SIZE    = 120,
  parameter int PADDED_SIZE = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MSG_SIZE+1)-1:0] msg_len,
  input  logic [MSG_SIZE-1:0]           message,
  output logic                          busy,
  output logic                          done,
  output logic [255:0]                  hashed
);

  localparam int LEN_W = $clog2(MSG_SIZE + 1);

  if (MSG_SIZE < 1 || MSG_SIZE > 447) begin : g_bad_msg_size
    $error("sha256_top: MSG_SIZE must be in 1..447");
  end
  if (PADDED_SIZE != 512) begin : g_bad_padded_size
    $error("sha256_top: PADDED_SIZE must be 512");
  end

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  sha_state_t  st_q, st_d, st_rnd;
  w_window_t   w_q, w_d, w_next, w_load;
  sha_state_t  hashed_q, hashed_d;
  logic        done_q, done_d;

  logic [LEN_W-1:0]    eff_len;
  logic [9:0]          len10;
  logic [MSG_SIZE-1:0] msg_masked;
  logic [511:0]        block;

  // Message is left-justified at bit 511, followed by the 1 marker; the length sits in the low word.
  always_comb begin
    eff_len    = (msg_len > LEN_W'(MSG_SIZE)) ? LEN_W'(MSG_SIZE) : msg_len;
    len10      = 10'(eff_len);
    msg_masked = message & ({MSG_SIZE{1'b1}} >> (10'(MSG_SIZE) - len10));
    block      = (512'(msg_masked) << (10'd512 - len10))
               | (512'd1 << (10'd511 - len10))
               | 512'(eff_len);
    for (int i = 0; i < 16; i++) begin
      w_load[i] = block[32*(15-i) +: 32];
    end
  end

`ifdef SHA256_UNROLL2_EN
  localparam logic [5:0] T_STEP = 6'd2;
  localparam logic [5:0] T_LAST = 6'd62;
  sha_state_t st_mid;

  sha256_round u_round0 (.st_i(st_q),   .w_i(w_q[0]), .k_i(K[t_q]),         .st_o(st_mid));
  sha256_round u_round1 (.st_i(st_mid), .w_i(w_q[1]), .k_i(K[t_q + 6'd1]),  .st_o(st_rnd));

  assign w_next = {sched_word(w_q[15], w_q[10], w_q[2], w_q[1]),
                   sched_word(w_q[14], w_q[9],  w_q[1], w_q[0]),
                   w_q[15:2]};
`else
  localparam logic [5:0] T_STEP = 6'd1;
  localparam logic [5:0] T_LAST = 6'd63;

  sha256_round u_round0 (.st_i(st_q), .w_i(w_q[0]), .k_i(K[t_q]), .st_o(st_rnd));

  assign w_next = {sched_word(w_q[14], w_q[9], w_q[1], w_q[0]), w_q[15:1]};
`endif

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    st_d     = st_q;
    w_d      = w_q;
    hashed_d = hashed_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ROUND;
          t_d     = '0;
          st_d    = H_INIT;
          w_d     = w_load;
        end
      end
      S_ROUND: begin
        st_d = st_rnd;
        w_d  = w_next;
        t_d  = t_q + T_STEP;
        if (t_q == T_LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hashed_d[i] = H_INIT[i] + st_q[i];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      st_q     <= '0;
      w_q      <= '0;
      hashed_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      st_q     <= st_d;
      w_q      <= w_d;
      hashed_q <= hashed_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hashed = hashed_q;

endmodule

// File: tb/tb_sha256_top.sv
// tb/tb_sha256_top.sv - randomized self-checking bench for sha256_top against a reference SHA-256
module tb_sha256_top;

  localparam int MSG_SIZE = 120;
  localparam int LEN_W    = $clog2(MSG_SIZE + 1);
`ifdef SHA256_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [MSG_SIZE-1:0] ABC_MSG = 120'h616263;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [LEN_W-1:0]    msg_len = '0;
  logic [MSG_SIZE-1:0] message = '0;
  logic                busy, done;
  logic [255:0]        hashed;

  int total = 0;
  int bad   = 0;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] h0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  sha256_top #(.MSG_SIZE(MSG_SIZE), .PADDED_SIZE(512)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .message(message), .busy(busy), .done(done), .hashed(hashed)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input logic [MSG_SIZE-1:0] msg, input int len);
    logic [511:0] blk;
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    int l;
    l = (len > MSG_SIZE) ? MSG_SIZE : len;
    blk = '0;
    for (int i = 0; i < l; i++) blk[511-i] = msg[l-1-i];
    blk[511-l] = 1'b1;
    blk[63:0] = 64'(l);
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h0[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    return {h0[0]+v[0], h0[1]+v[1], h0[2]+v[2], h0[3]+v[3], h0[4]+v[4], h0[5]+v[5], h0[6]+v[6], h0[7]+v[7]};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start-sampling edge.
  task automatic start_hash(input logic [MSG_SIZE-1:0] m, input int len);
    message = m;
    msg_len = LEN_W'(len);
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= budget && lat < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  initial begin
    int lat, lat2, npulse, len;
    bit bok;
    logic [255:0] d1, exp_d;
    logic [MSG_SIZE-1:0] m;

    repeat (3) @(negedge clk);
    check("rst_busy",   256'(busy),  256'(0));
    check("rst_done",   256'(done),  256'(0));
    check("rst_hashed", hashed,      256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    start_hash(ABC_MSG, 24);
    wait_done(200, lat, bok);
    check("abc_digest", hashed, ABC_DIG);
    check("abc_lat",    256'(lat), 256'(LAT));
    check("abc_busy",   256'(bok), 256'(1));
    @(negedge clk);
    check("abc_done_1cyc", 256'(done), 256'(0));
    check("abc_hold",      hashed, ABC_DIG);

    start_hash({$urandom, $urandom, $urandom, $urandom}, 0);
    wait_done(200, lat, bok);
    check("empty_digest", hashed, EMPTY_DIG);
    check("empty_lat",    256'(lat), 256'(LAT));

    start_hash({{96{1'b1}}, 24'h616263}, 24);
    wait_done(200, lat, bok);
    check("upper_ignored", hashed, ABC_DIG);

    // Start while busy is dropped; mid-hash input changes must not leak in.
    start_hash(ABC_MSG, 24);
    npulse = 0;
    lat = -1;
    d1 = '0;
    for (int c = 1; c <= 150; c++) begin
      if (c == 10) begin
        message = '0;
        msg_len = '0;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        npulse++;
        if (lat < 0) begin
          lat = c;
          d1 = hashed;
        end
      end
    end
    check("busy_start_pulses", 256'(npulse), 256'(1));
    check("busy_start_lat",    256'(lat),    256'(LAT));
    check("busy_start_digest", d1,           ABC_DIG);

    start_hash(ABC_MSG, 24);
    repeat (29) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   256'(busy), 256'(0));
    check("midrst_done",   256'(done), 256'(0));
    check("midrst_hashed", hashed,     256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_hash(ABC_MSG, 24);
    wait_done(200, lat, bok);
    check("post_rst_digest", hashed,    ABC_DIG);
    check("post_rst_lat",    256'(lat), 256'(LAT));

    start_hash(ABC_MSG, 24);
    wait_done(200, lat, bok);
    d1 = hashed;
    start_hash('0, 0);
    wait_done(200, lat2, bok);
    check("b2b_first",  d1,               ABC_DIG);
    check("b2b_second", hashed,           EMPTY_DIG);
    check("b2b_gap",    256'(lat2 + 1),   256'(LAT + 1));

    for (int n = 0; n < 12; n++) begin
      m = MSG_SIZE'({$urandom, $urandom, $urandom, $urandom});
      len = (n == 0) ? MSG_SIZE : (n == 1) ? 127 : int'($urandom_range(0, 127));
      exp_d = ref_hash(m, len);
      start_hash(m, len);
      wait_done(200, lat, bok);
      check($sformatf("rand%0d_len%0d", n, len), hashed, exp_d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
